// File: rtl/vga_arb_pkg.sv
// Shared types and default geometry for the VGA pixel-write arbiter.
package vga_arb_pkg;

    // Arbiter operating modes.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_CLEAR = 2'd2
    } arb_state_e;

    // Default screen geometry (160x120, 3-bit colour) and client count.
    localparam int N_REQ_DEF = 4;
    localparam int X_W_DEF   = 8;
    localparam int Y_W_DEF   = 7;
    localparam int C_W_DEF   = 3;
    localparam int X_MAX_DEF = 159;
    localparam int Y_MAX_DEF = 119;

    // Number of pixels written by one full-screen clear.
    localparam int CLEAR_PIXELS = (X_MAX_DEF + 1) * (Y_MAX_DEF + 1);

endpackage

// File: rtl/vga_write_arbiter_if.sv
// Client-side pixel handshake, clear control and adapter write port.
interface vga_write_arbiter_if import vga_arb_pkg::*; #(
    parameter int N_REQ = N_REQ_DEF,
    parameter int X_W   = X_W_DEF,
    parameter int Y_W   = Y_W_DEF,
    parameter int C_W   = C_W_DEF
);
    logic [N_REQ-1:0]     req;
    logic [N_REQ-1:0]     px_valid;
    logic [N_REQ*X_W-1:0] px_x;
    logic [N_REQ*Y_W-1:0] px_y;
    logic [N_REQ*C_W-1:0] px_colour;
    logic [N_REQ-1:0]     px_last;
    logic [N_REQ-1:0]     gnt;
    logic [N_REQ-1:0]     px_ready;
    logic                 clear_req;
    logic [C_W-1:0]       clear_colour;
    logic                 clear_busy;
    logic [X_W-1:0]       vga_x;
    logic [Y_W-1:0]       vga_y;
    logic [C_W-1:0]       vga_colour;
    logic                 vga_plot;

    // Drawing clients plus the adapter sink.
    modport master (
        output req, px_valid, px_x, px_y, px_colour, px_last, clear_req, clear_colour,
        input  gnt, px_ready, clear_busy, vga_x, vga_y, vga_colour, vga_plot
    );

    // The arbiter itself.
    modport slave (
        input  req, px_valid, px_x, px_y, px_colour, px_last, clear_req, clear_colour,
        output gnt, px_ready, clear_busy, vga_x, vga_y, vga_colour, vga_plot
    );

endinterface

// File: rtl/vga_write_arbiter_rr_picker.sv
// Combinational round-robin selector: first requester above last_gnt, one-hot.
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int LG_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [LG_W-1:0]  last_gnt,
    output logic [N_REQ-1:0] pick,
    output logic             any
);

    // Scan upward from last_gnt+1 (wrapping) and keep the first hit.
    always_comb begin
        int idx;
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        pick = '0;
        any  = 1'b0;
        idx  = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last_gnt) + k) % N_REQ;
            if (!any && req[idx]) begin
                pick[idx] = 1'b1;
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_write_arbiter.sv
// Round-robin burst arbiter for the VGA pixel-write port with a built-in
// full-screen clear sequencer.
module vga_write_arbiter import vga_arb_pkg::*; #(
    parameter int N_REQ = N_REQ_DEF,
    parameter int X_W   = X_W_DEF,
    parameter int Y_W   = Y_W_DEF,
    parameter int C_W   = C_W_DEF,
    parameter int X_MAX = X_MAX_DEF,
    parameter int Y_MAX = Y_MAX_DEF
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    vga_write_arbiter_if.slave  bus
);

    localparam int LG_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_BURST = ST_BURST;
    localparam logic [1:0] S_CLEAR = ST_CLEAR;

    localparam logic [X_W-1:0] X_LIM = X_W'(X_MAX);
    localparam logic [Y_W-1:0] Y_LIM = Y_W'(Y_MAX);

    logic [1:0]       state;
    logic [N_REQ-1:0] gnt_q;
    logic [LG_W-1:0]  last_gnt;
    logic [LG_W-1:0]  gnt_idx;
    logic             clear_pending;
    logic             clear_done;
    logic [C_W-1:0]   clear_col;
    logic [X_W-1:0]   cx;
    logic [Y_W-1:0]   cy;
    logic [N_REQ-1:0] pick;
    logic             pick_any;

    logic [X_W-1:0]   sel_x;
    logic [Y_W-1:0]   sel_y;
    logic [C_W-1:0]   sel_c;
    logic             sel_req;
    logic             sel_valid;
    logic             sel_last;
    logic             in_range;

    logic [X_W-1:0]   vga_x_q;
    logic [Y_W-1:0]   vga_y_q;
    logic [C_W-1:0]   vga_c_q;
    logic             vga_plot_q;

    rr_picker #(.N_REQ(N_REQ), .LG_W(LG_W)) u_picker (
        .req      (bus.req),
        .last_gnt (last_gnt),
        .pick     (pick),
        .any      (pick_any)
    );

    // Encode the one-hot grant into an index for the unpacking mux.
    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_q[i]) gnt_idx = LG_W'(i);
        end
    end

    // Unpack the granted client's pixel fields.
    always_comb begin
        sel_x     = bus.px_x[int'(gnt_idx)*X_W +: X_W];
        sel_y     = bus.px_y[int'(gnt_idx)*Y_W +: Y_W];
        sel_c     = bus.px_colour[int'(gnt_idx)*C_W +: C_W];
        sel_req   = bus.req[gnt_idx];
        sel_valid = bus.px_valid[gnt_idx];
        sel_last  = bus.px_last[gnt_idx];
        in_range  = (sel_x <= X_LIM) && (sel_y <= Y_LIM);
    end

    // Ready follows the grant, but a client that has dropped req is never accepted.
    assign bus.px_ready   = gnt_q & bus.req;
    assign bus.gnt        = gnt_q;
    assign bus.clear_busy = clear_pending | (state == S_CLEAR);
    assign bus.vga_x      = vga_x_q;
    assign bus.vga_y      = vga_y_q;
    assign bus.vga_colour = vga_c_q;
    assign bus.vga_plot   = vga_plot_q;

    // FSM, clear latch, clear counters and the registered adapter write port.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            gnt_q         <= '0;
            last_gnt      <= LG_W'(N_REQ - 1);
            clear_pending <= 1'b0;
            clear_done    <= 1'b0;
            clear_col     <= '0;
            cx            <= '0;
            cy            <= '0;
            vga_x_q       <= '0;
            vga_y_q       <= '0;
            vga_c_q       <= '0;
            vga_plot_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every branch below sees pre-edge register values.
            vga_plot_q <= 1'b0;

            // A clear request during CLEAR is dropped; otherwise it (re)captures the colour.
            if (state != S_CLEAR && bus.clear_req) begin
                clear_pending <= 1'b1;
                clear_col     <= bus.clear_colour;
            end

            case (state)
                S_IDLE: begin
                    if (clear_pending) begin
                        state      <= S_CLEAR;
                        cx         <= '0;
                        cy         <= '0;
                        clear_done <= 1'b0;
                    end else if (pick_any) begin
                        gnt_q <= pick;
                        state <= S_BURST;
                    end
                end

                S_BURST: begin
                    if (!sel_req) begin
                        state    <= S_IDLE;
                        gnt_q    <= '0;
                        last_gnt <= gnt_idx;
                    end else if (sel_valid) begin
                        vga_x_q    <= sel_x;
                        vga_y_q    <= sel_y;
                        vga_c_q    <= sel_c;
                        vga_plot_q <= in_range;
                        if (sel_last) begin
                            state    <= S_IDLE;
                            gnt_q    <= '0;
                            last_gnt <= gnt_idx;
                        end
                    end
                end

                S_CLEAR: begin
                    // One cycle after the final pixel is on the port, release the clear.
                    if (clear_done) begin
                        clear_pending <= 1'b0;
                        clear_done    <= 1'b0;
                        state         <= S_IDLE;
                    end else begin
                        vga_x_q    <= cx;
                        vga_y_q    <= cy;
                        vga_c_q    <= clear_col;
                        vga_plot_q <= 1'b1;
                        if (cx == X_LIM) begin
                            cx <= '0;
                            if (cy == Y_LIM) clear_done <= 1'b1;
                            else             cy <= cy + 1'b1;
                        end else begin
                            cx <= cx + 1'b1;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
